// File: rtl/adder_share_ctrl.sv
// -----------------------------------------------------------------------------
// adder_share_ctrl
//
// Time-shares one external registered adder (y = a + b, one-cycle latency)
// between NUM_REQ requesters. Pending requests are arbitrated, the winner's
// operands are registered onto add_a/add_b, and the adder result is captured
// two edges after the grant. The result is returned with the requester index,
// and that requester receives a one-cycle ack.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   req      in   [NUM_REQ]        request lines, level-held until ack
//   a_in     in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in     in   [NUM_REQ*WIDTH]  operand B, same packing as a_in
//   ack      out  [NUM_REQ]        one-cycle completion pulse
//   y_out    out  [WIDTH]          captured sum
//   y_id     out  [ID_W]           owner of y_out
//   y_valid  out                   one-cycle result strobe
//   busy     out                   FSM is not in IDLE
//   add_a    out  [WIDTH]          registered operand A to the shared adder
//   add_b    out  [WIDTH]          registered operand B to the shared adder
//   add_y    in   [WIDTH]          shared adder result
//
// Build option:
//   ADDER_SHARE_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                           no round-robin pointer.
//                              undefined -> round-robin arbitration.
// -----------------------------------------------------------------------------
module adder_share_ctrl #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         y_out,
    output logic [ID_W-1:0]          y_id,
    output logic                     y_valid,
    output logic                     busy,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [WIDTH-1:0]    r_y_out;
    logic [ID_W-1:0]     r_y_id;
    logic                r_y_valid;
    logic [WIDTH-1:0]    r_add_a;
    logic [WIDTH-1:0]    r_add_b;

    logic                w_any;
    logic [ID_W-1:0]     w_gnt;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;

`ifdef ADDER_SHARE_FIXED_PRIO_EN
    // Lowest-index pending requester always wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req[j] && !w_any) begin
                w_any = 1'b1;
                w_gnt = j[ID_W-1:0];
            end
        end
    end
`else
    logic [ID_W-1:0]     r_ptr;
    logic                w_hit_hi;
    logic [ID_W-1:0]     w_gnt_hi;
    logic [ID_W-1:0]     w_gnt_lo;

    // Circular search from r_ptr: prefer the first set bit at or above the
    // pointer; otherwise wrap to the first set bit overall (which is then
    // necessarily below the pointer).
    always_comb begin
        w_any    = 1'b0;
        w_hit_hi = 1'b0;
        w_gnt_hi = '0;
        w_gnt_lo = '0;
        w_gnt    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req[j]) begin
                if (!w_any) begin
                    w_any    = 1'b1;
                    w_gnt_lo = j[ID_W-1:0];
                end
                if (!w_hit_hi && (j >= 32'(r_ptr))) begin
                    w_hit_hi = 1'b1;
                    w_gnt_hi = j[ID_W-1:0];
                end
            end
        end
        w_gnt = w_hit_hi ? w_gnt_hi : w_gnt_lo;
    end

    // Winner drops to lowest priority once its result is captured.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_ptr <= (32'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + ID_W'(1);
        end
    end
`endif

    // Operand select for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (32'(w_gnt) == j) begin
                w_sel_a = a_in[j*WIDTH +: WIDTH];
                w_sel_b = b_in[j*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant   <= '0;
            r_ack     <= '0;
            r_y_out   <= '0;
            r_y_id    <= '0;
            r_y_valid <= 1'b0;
            r_add_a   <= '0;
            r_add_b   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_add_a <= w_sel_a;
                        r_add_b <= w_sel_b;
                        r_grant <= w_gnt;
                    end
                end
                S_CAPTURE: begin
                    r_y_out   <= add_y;
                    r_y_id    <= r_grant;
                    r_y_valid <= 1'b1;
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        r_ack[j] <= (32'(r_grant) == j);
                    end
                end
                S_DONE: begin
                    r_y_valid <= 1'b0;
                    r_ack     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ack     = r_ack;
    assign y_out   = r_y_out;
    assign y_id    = r_y_id;
    assign y_valid = r_y_valid;
    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for adder_share_ctrl. Provides the shared registered adder,
// drives directed and randomized operations and checks every output against
// an operation-level reference model (arbitration by circular distance from
// the priority pointer, sum modulo 2^WIDTH).
// -----------------------------------------------------------------------------
module tb_adder_share_ctrl;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ID_W    = 1;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         y_out;
    logic [ID_W-1:0]          y_id;
    logic                     y_valid;
    logic                     busy;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_y;

    int n_checks;
    int n_errors;
    int model_ptr;
    logic [WIDTH-1:0] opa [NUM_REQ];
    logic [WIDTH-1:0] opb [NUM_REQ];

    adder_share_ctrl #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .y_out   (y_out),
        .y_id    (y_id),
        .y_valid (y_valid),
        .busy    (busy),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_y   (add_y)
    );

    // Shared external adder: registered, one-cycle latency, no carry-out.
    always @(posedge clock) add_y <= add_a + add_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Winner = pending requester at the smallest circular distance from the
    // priority pointer (fixed priority: smallest index).
    function automatic int model_winner(input logic [NUM_REQ-1:0] p);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p[i]) begin
`ifdef ADDER_SHARE_FIXED_PRIO_EN
                d = i;
`else
                d = (i - model_ptr + NUM_REQ) % NUM_REQ;
`endif
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic load_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            a_in[i*WIDTH +: WIDTH] = opa[i];
            b_in[i*WIDTH +: WIDTH] = opb[i];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"},     32'(ack),     0);
        chk({tag, "_y_valid"}, 32'(y_valid), 0);
        chk({tag, "_y_out"},   32'(y_out),   0);
        chk({tag, "_y_id"},    32'(y_id),    0);
        chk({tag, "_add_a"},   32'(add_a),   0);
        chk({tag, "_add_b"},   32'(add_b),   0);
        chk({tag, "_busy"},    32'(busy),    0);
    endtask

    task automatic idle_tick();
        req = '0;
        tick();
        chk("idle_busy",    32'(busy),    0);
        chk("idle_y_valid", 32'(y_valid), 0);
        chk("idle_ack",     32'(ack),     0);
    endtask

    // Presents the request set 'reqs' (operands from opa/opb) and serves every
    // requester to completion. Each winner deasserts after its ack. With
    // 'scramble' the winner's operands change right after grant; with
    // 'drop_early' the winner's req drops right after grant.
    task automatic serve(input logic [NUM_REQ-1:0] reqs, input bit scramble, input bit drop_early);
        logic [NUM_REQ-1:0] pend;
        int w;
        int exp_sum;
        pend = reqs;
        load_operands();
        req = pend;
        while (pend != '0) begin
            w       = model_winner(pend);
            exp_sum = (int'(opa[w]) + int'(opb[w])) % (1 << WIDTH);
            tick();
            chk("grant_busy",    32'(busy),    1);
            chk("grant_add_a",   32'(add_a),   32'(opa[w]));
            chk("grant_add_b",   32'(add_b),   32'(opb[w]));
            chk("grant_y_valid", 32'(y_valid), 0);
            if (scramble) begin
                a_in[w*WIDTH +: WIDTH] = WIDTH'(99);
                b_in[w*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            if (drop_early) begin
                pend[w] = 1'b0;
                req     = pend;
            end
            tick();
            chk("issue_busy",    32'(busy),    1);
            chk("issue_y_valid", 32'(y_valid), 0);
            chk("issue_ack",     32'(ack),     0);
            tick();
            chk("done_y_valid",  32'(y_valid), 1);
            chk("done_y_out",    32'(y_out),   32'(exp_sum));
            chk("done_y_id",     32'(y_id),    w);
            chk("done_ack",      32'(ack),     32'(1 << w));
            chk("done_busy",     32'(busy),    1);
            pend[w]   = 1'b0;
            req       = pend;
            model_ptr = (w + 1) % NUM_REQ;
            tick();
            chk("post_y_valid",  32'(y_valid), 0);
            chk("post_ack",      32'(ack),     0);
            chk("post_busy",     32'(busy),    0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_ptr = 0;
        reset     = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Reset for 5 cycles, then reset values.
        repeat (5) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (3) idle_tick();

        // Single request: 2 + 3.
        opa[0] = 8'd2;   opb[0] = 8'd3;
        serve(2'b01, 1'b0, 1'b0);

        // Overflow: 200 + 100 wraps to 44.
        opa[0] = 8'd200; opb[0] = 8'd100;
        serve(2'b01, 1'b0, 1'b0);

        // Pointer back to 0, then contention: id0 first.
        opa[1] = 8'd7;   opb[1] = 8'd8;
        serve(2'b10, 1'b0, 1'b0);
        opa[0] = 8'd4;   opb[0] = 8'd5;
        opa[1] = 8'd10;  opb[1] = 8'd30;
        serve(2'b11, 1'b0, 1'b0);

        // Pointer at 1, then contention: id1 first (round-robin build).
        opa[0] = 8'd1;   opb[0] = 8'd1;
        serve(2'b01, 1'b0, 1'b0);
        opa[0] = 8'd4;   opb[0] = 8'd5;
        opa[1] = 8'd10;  opb[1] = 8'd30;
        serve(2'b11, 1'b0, 1'b0);

        // Operand change after grant is ignored: 4 + 5, not 99 + x.
        opa[0] = 8'd4;   opb[0] = 8'd5;
        serve(2'b01, 1'b1, 1'b0);

        // Req dropped after grant still completes.
        opa[1] = 8'd250; opb[1] = 8'd9;
        serve(2'b10, 1'b0, 1'b1);
        idle_tick();

        // Randomized operations.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                opa[i] = WIDTH'($urandom);
                opb[i] = WIDTH'($urandom);
            end
            serve(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) idle_tick();
        end

        // Leave the pointer at 1 so its reset is observable.
        opa[0] = 8'd3;   opb[0] = 8'd3;
        serve(2'b01, 1'b0, 1'b0);

        // Reset during CAPTURE: no result, all outputs cleared.
        opa[0] = 8'd20;  opb[0] = 8'd22;
        load_operands();
        req = 2'b01;
        tick();                 // grant, now ISSUE
        tick();                 // now CAPTURE
        reset = 1'b1;
        req   = '0;
        tick();
        check_outputs_zero("rst_capture");
        reset     = 1'b0;
        model_ptr = 0;
        tick();
        chk("rst_after_y_valid", 32'(y_valid), 0);
        chk("rst_after_ack",     32'(ack),     0);
        chk("rst_after_busy",    32'(busy),    0);

        // Normal operation resumes, pointer back at 0.
        opa[0] = 8'd4;   opb[0] = 8'd5;
        opa[1] = 8'd10;  opb[1] = 8'd30;
        serve(2'b11, 1'b0, 1'b0);
        idle_tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
